lsu_mem_ctrl: RTL and testbench

Load/store unit sitting between the RV32I core's memory stage and a variable-latency data memory. It converts core loads and stores (lb/lh/lw/lbu/lhu/sb/sh/sw) into word-aligned memory transactions with byte enables. It stalls the core until each transaction completes and returns sign- or zero-extended load data. Misaligned addresses and illegal funct3 values are flagged without touching memory.

---
 rtl/lsu_mem_ctrl.sv | 150 +++++++++++++++
 tb/tb_lsu_mem_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit: turns RV32I loads/stores into word-aligned memory transactions
// with byte enables, stalls the core until completion and extends load data.
module lsu_mem_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        misaligned,
  output logic        illegal,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ready,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_R, DONE} state_e;

  state_e      state_q;
  logic        mem_req_q, mem_we_q, rdata_valid_q;
  logic [31:0] mem_addr_q, mem_wdata_q, rdata_q;
  logic [3:0]  mem_be_q;
  logic [2:0]  funct3_q;
  logic [1:0]  off_q;

  logic        f3_legal_c, misalign_c, in_idle_c, accept_c;
  logic [3:0]  be_d;
  logic [31:0] wdata_d, rdata_d;
  logic [7:0]  lane_b_c;
  logic [15:0] lane_h_c;

  // Request decode: legality, alignment and acceptance in IDLE
  always_comb begin
    f3_legal_c = 1'b0;
    if (req_we) begin
      f3_legal_c = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
                   (req_funct3 == 3'b010);
    end else begin
      f3_legal_c = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
                   (req_funct3 == 3'b010) || (req_funct3 == 3'b100) ||
                   (req_funct3 == 3'b101);
    end
    misalign_c = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                 ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    in_idle_c  = (state_q == IDLE);
    illegal    = in_idle_c && req_valid && !f3_legal_c;
    misaligned = in_idle_c && req_valid && f3_legal_c && misalign_c;
    accept_c   = in_idle_c && req_valid && f3_legal_c && !misalign_c;
    stall      = accept_c || (state_q == ISSUE) || (state_q == WAIT_R);
  end

  // Store lane placement
  always_comb begin
    be_d    = 4'b1111;
    wdata_d = req_wdata;
    case (req_funct3[1:0])
      2'b00: begin
        be_d    = 4'b0001 << req_addr[1:0];
        wdata_d = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        be_d    = req_addr[1] ? 4'b1100 : 4'b0011;
        wdata_d = {2{req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Load lane selection and extension, using the captured offset and funct3
  always_comb begin
    lane_h_c = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (off_q)
      2'd0:    lane_b_c = mem_rdata[7:0];
      2'd1:    lane_b_c = mem_rdata[15:8];
      2'd2:    lane_b_c = mem_rdata[23:16];
      default: lane_b_c = mem_rdata[31:24];
    endcase
    case (funct3_q)
      3'b000:  rdata_d = {{24{lane_b_c[7]}}, lane_b_c};
      3'b001:  rdata_d = {{16{lane_h_c[15]}}, lane_h_c};
      3'b100:  rdata_d = {24'd0, lane_b_c};
      3'b101:  rdata_d = {16'd0, lane_h_c};
      default: rdata_d = mem_rdata;
    endcase
  end

  // Transaction FSM with registered memory-side and load-result outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= 32'd0;
      mem_wdata_q   <= 32'd0;
      mem_be_q      <= 4'd0;
      rdata_q       <= 32'd0;
      rdata_valid_q <= 1'b0;
      funct3_q      <= 3'd0;
      off_q         <= 2'd0;
    end else begin
      rdata_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept_c) begin
            state_q     <= ISSUE;
            mem_req_q   <= 1'b1;
            mem_we_q    <= req_we;
            mem_addr_q  <= {req_addr[31:2], 2'b00};
            mem_wdata_q <= wdata_d;
            mem_be_q    <= req_we ? be_d : 4'b0000;
            funct3_q    <= req_funct3;
            off_q       <= req_addr[1:0];
          end
        end
        ISSUE: begin
          if (mem_ready) begin
            mem_req_q <= 1'b0;
            state_q   <= mem_we_q ? DONE : WAIT_R;
          end
        end
        WAIT_R: begin
          if (mem_rvalid) begin
            rdata_q       <= rdata_d;
            rdata_valid_q <= 1'b1;
            state_q       <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign mem_be      = mem_be_q;
  assign rdata       = rdata_q;
  assign rdata_valid = rdata_valid_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl: per-cycle expectations from a lane/extension
// model, compared every cycle, plus literal load results.
module tb_lsu_mem_ctrl;

  logic        clk, reset;
  logic        req_valid, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        stall, rdata_valid, misaligned, illegal;
  logic [31:0] rdata;
  logic        mem_req, mem_we, mem_ready, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  int n_chk = 0;
  int n_err = 0;
  logic chk_on = 1'b0;

  // Expected outputs for the current cycle
  logic        e_stall, e_req, e_we, e_rdv, e_mis, e_ill;
  logic [31:0] e_addr, e_wd, e_rdata;
  logic [3:0]  e_be;

  lsu_mem_ctrl dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_we(req_we), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall), .rdata(rdata), .rdata_valid(rdata_valid),
    .misaligned(misaligned), .illegal(illegal),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
    if (f3[1:0] == 2'b00) return 4'(1 << a[1:0]);
    if (f3[1:0] == 2'b01) return 4'(3 << (a[1:0] & 2'b10));
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_wd(input logic [2:0] f3, input logic [31:0] w);
    if (f3[1:0] == 2'b00) return 32'(w[7:0]) * 32'h01010101;
    if (f3[1:0] == 2'b01) return 32'(w[15:0]) * 32'h00010001;
    return w;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] w);
    logic [31:0] v;
    case (f3)
      3'b000, 3'b100: begin
        v = (w >> (8 * int'(a[1:0]))) & 32'hFF;
        if (f3 == 3'b000 && v >= 32'd128) v = v + 32'hFFFFFF00;
      end
      3'b001, 3'b101: begin
        v = (w >> (16 * int'(a[1]))) & 32'hFFFF;
        if (f3 == 3'b001 && v >= 32'd32768) v = v + 32'hFFFF0000;
      end
      default: v = w;
    endcase
    return v;
  endfunction

  task automatic set_exp(input logic s, input logic r, input logic w, input logic [31:0] a,
                         input logic [3:0] b, input logic [31:0] wd, input logic rv,
                         input logic mi, input logic il);
    e_stall = s; e_req = r; e_we = w; e_addr = a; e_be = b; e_wd = wd;
    e_rdv = rv; e_mis = mi; e_ill = il;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Single compare process, mid-cycle
  always @(negedge clk) begin
    if (chk_on && !reset) begin
      chk("stall", 32'(stall), 32'(e_stall));
      chk("mem_req", 32'(mem_req), 32'(e_req));
      chk("rdata_valid", 32'(rdata_valid), 32'(e_rdv));
      chk("misaligned", 32'(misaligned), 32'(e_mis));
      chk("illegal", 32'(illegal), 32'(e_ill));
      chk("rdata", rdata, e_rdata);
      if (e_req) begin
        chk("mem_we", 32'(mem_we), 32'(e_we));
        chk("mem_addr", mem_addr, e_addr);
        chk("mem_be", 32'(mem_be), 32'(e_be));
        if (e_we) chk("mem_wdata", mem_wdata, e_wd);
      end
    end
  end

  // One legal transaction: n ready-wait cycles, m extra rvalid-wait cycles
  task automatic do_txn(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input int n, input int m,
                        input logic [31:0] rword, input logic lit_on,
                        input logic [31:0] lit);
    next_cycle();
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    mem_ready = 1'b0; mem_rvalid = 1'b0;
    set_exp(1'b1, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i <= n; i++) begin
      next_cycle();
      mem_ready = (i == n);
      set_exp(1'b1, 1'b1, we, a & 32'hFFFF_FFFC, we ? m_be(f3, a) : 4'd0,
              m_wd(f3, wd), 1'b0, 1'b0, 1'b0);
    end
    if (!we) begin
      for (int j = 0; j <= m; j++) begin
        next_cycle();
        mem_ready = 1'b0;
        mem_rvalid = (j == m);
        mem_rdata = (j == m) ? rword : ~rword;
        set_exp(1'b1, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0, 1'b0, 1'b0, 1'b0);
      end
    end
    next_cycle();
    mem_ready = 1'b0; mem_rvalid = 1'b0;
    if (!we) e_rdata = m_load(f3, a, rword);
    set_exp(1'b0, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0, !we, 1'b0, 1'b0);
    if (lit_on) chk("load_literal", rdata, lit);
    // Stray read-valid while idle must be ignored
    next_cycle();
    req_valid = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
    set_exp(1'b0, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    next_cycle();
    mem_rvalid = 1'b0;
  endtask

  task automatic do_fault(input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic mi, input logic il);
    next_cycle();
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = 32'h5A5A5A5A;
    mem_ready = 1'b1; mem_rvalid = 1'b0;
    set_exp(1'b0, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0, 1'b0, mi, il);
    next_cycle();
    req_valid = 1'b0; mem_ready = 1'b0;
    set_exp(1'b0, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
    e_rdata = 32'd0;
    set_exp(1'b0, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_be", 32'(mem_be), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_rdata_valid", 32'(rdata_valid), 32'd0);
    chk("rst_faults", 32'({misaligned, illegal}), 32'd0);
    reset = 1'b0;
    chk_on = 1'b1;

    // sw then lw
    do_txn(1'b1, 3'b010, 32'h64, 32'h19, 0, 0, 32'd0, 1'b0, 32'd0);
    do_txn(1'b0, 3'b010, 32'h64, 32'd0, 0, 0, 32'h00000019, 1'b1, 32'h00000019);
    // store lanes
    do_txn(1'b1, 3'b000, 32'h103, 32'hAB, 0, 0, 32'd0, 1'b0, 32'd0);
    do_txn(1'b1, 3'b001, 32'h102, 32'h1234, 0, 0, 32'd0, 1'b0, 32'd0);
    do_txn(1'b1, 3'b000, 32'h101, 32'hCAFE00C3, 2, 0, 32'd0, 1'b0, 32'd0);
    do_txn(1'b1, 3'b001, 32'h200, 32'h8765BEEF, 1, 0, 32'd0, 1'b0, 32'd0);
    // load extension
    do_txn(1'b0, 3'b000, 32'h201, 32'd0, 0, 0, 32'h80FF7F01, 1'b1, 32'h0000007F);
    do_txn(1'b0, 3'b000, 32'h202, 32'd0, 0, 0, 32'h80FF7F01, 1'b1, 32'hFFFFFFFF);
    do_txn(1'b0, 3'b100, 32'h203, 32'd0, 0, 0, 32'h80FF7F01, 1'b1, 32'h00000080);
    do_txn(1'b0, 3'b001, 32'h202, 32'd0, 0, 0, 32'h80FF7F01, 1'b1, 32'hFFFF80FF);
    do_txn(1'b0, 3'b101, 32'h202, 32'd0, 0, 0, 32'h80FF7F01, 1'b1, 32'h000080FF);
    do_txn(1'b0, 3'b001, 32'h200, 32'd0, 0, 1, 32'h80FF7F01, 1'b1, 32'h00007F01);
    // a store must leave rdata untouched
    do_txn(1'b1, 3'b010, 32'h300, 32'h11223344, 0, 0, 32'd0, 1'b0, 32'd0);
    // wait states: ready low 3 cycles, rvalid 2 cycles after accept
    do_txn(1'b0, 3'b010, 32'h400, 32'd0, 3, 1, 32'hA5A5F00D, 1'b1, 32'hA5A5F00D);
    // faults
    do_fault(1'b0, 3'b010, 32'h66, 1'b1, 1'b0);
    do_fault(1'b0, 3'b011, 32'h64, 1'b0, 1'b1);
    do_fault(1'b1, 3'b100, 32'h64, 1'b0, 1'b1);
    do_fault(1'b0, 3'b001, 32'h1, 1'b1, 1'b0);
    do_fault(1'b1, 3'b011, 32'h67, 1'b0, 1'b1);

    // reset during WAIT_R
    next_cycle();
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h500;
    set_exp(1'b1, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    next_cycle();
    mem_ready = 1'b1;
    set_exp(1'b1, 1'b1, 1'b0, 32'h500, 4'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    next_cycle();
    mem_ready = 1'b0;
    set_exp(1'b1, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    reset = 1'b1; req_valid = 1'b0;
    #1;
    chk("arst_stall", 32'(stall), 32'd0);
    chk("arst_mem_req", 32'(mem_req), 32'd0);
    chk("arst_rdata_valid", 32'(rdata_valid), 32'd0);
    chk("arst_rdata", rdata, 32'd0);
    e_rdata = 32'd0;
    set_exp(1'b0, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    next_cycle();
    next_cycle();
    reset = 1'b0;
    next_cycle();
    mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
    next_cycle();
    mem_rvalid = 1'b0;
    next_cycle();
    // recovery after reset
    do_txn(1'b0, 3'b100, 32'h601, 32'd0, 0, 0, 32'h0000F200, 1'b1, 32'h000000F2);

    next_cycle();
    chk_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
